stage4_wb_ctrl: RTL and testbench

STAGE4_WB_CTRL -- requirements
Module: stage4_wb_ctrl

---
 rtl/stage4_wb_ctrl.sv | 175 +++++++++++++++++
 tb/tb_stage4_wb_ctrl.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/stage4_wb_ctrl.sv
// stage4_wb_ctrl -- stage-4 register-file writeback controller.
//
// Takes the stage-4 control word and chooses the write address and data.
// Link writes go to r31 with pc4_i. The other sources are the lo half of a
// pair write, memory data and the ALU result. The result is registered onto
// a single register-file write port.
//
// A pair write (pair_write=1, link=0) takes two cycles. The lo half is
// written on the accepting edge. The hi half is latched at that edge and
// written to (dest+1) mod 32 on the next edge, in state WB_HI. During the
// WB_HI cycle stall_o holds the upstream stage-4 register, and ctrl_i and
// flush_i are ignored.
//
// A write whose final address is 0 is suppressed. It still advances state
// and still retires.
//
// Optional feature: define STAGE4_RETIRE_CNT_EN to build a 16-bit
// saturating retired-instruction counter on retired_o. When the macro is
// not defined, retired_o is tied to 0.

module stage4_wb_ctrl #(
  parameter int DW = 32,
  parameter int CW = 18   // only 18 is supported
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [CW-1:0] ctrl_i,
  input  logic          flush_i,
  input  logic [DW-1:0] alu_i,
  input  logic [DW-1:0] mem_i,
  input  logic [DW-1:0] lo_i,
  input  logic [DW-1:0] hi_i,
  input  logic [DW-1:0] pc4_i,
  output logic          rf_we_o,
  output logic [4:0]    rf_waddr_o,
  output logic [DW-1:0] rf_wdata_o,
  output logic          stall_o,
  output logic [15:0]   retired_o
);

  typedef enum logic {
    IDLE  = 1'b0,
    WB_HI = 1'b1
  } state_t;

  state_t        state;
  logic [DW-1:0] hi_q;       // latched high half of a pair write
  logic [4:0]    hi_addr_q;  // (dest+1) mod 32, latched with hi_q

  // Control word fields
  logic [4:0] dest;
  logic       reg_write;
  logic       mem_to_reg;
  logic       pair_write;
  logic       link;
  logic       valid;

  assign dest       = ctrl_i[11:7];
  assign reg_write  = ctrl_i[6];
  assign mem_to_reg = ctrl_i[5];
  assign pair_write = ctrl_i[4];
  assign link       = ctrl_i[3];
  assign valid      = ctrl_i[0];

  // The opcode and reserved fields play no part in writeback control.
  logic unused_fields;
  assign unused_fields = ^{ctrl_i[17:12], ctrl_i[2:1]};

  logic       accept;      // IDLE takes a real write this cycle
  logic       start_pair;  // accepted write is the first half of a pair
  logic [4:0] dest_inc;    // 5-bit add, so dest=31 wraps to 0

  assign accept     = (state == IDLE) && valid && !flush_i && reg_write;
  assign start_pair = pair_write && !link;
  assign dest_inc   = dest + 5'd1;

  // Priority select of the write address and data: link, then pair lo,
  // then memory, then ALU.
  logic [4:0]    sel_addr;
  logic [DW-1:0] sel_data;

  always_comb begin
    // NOTE: give every output a default at the top of the block, so that
    // no path through it leaves a value unassigned and infers a latch.
    sel_addr = dest;
    sel_data = alu_i;
    if (link) begin
      sel_addr = 5'd31;
      sel_data = pc4_i;
    end else if (pair_write) begin
      sel_data = lo_i;
    end else if (mem_to_reg) begin
      sel_data = mem_i;
    end
  end

  // Writeback FSM. Every output is registered. Address and data are zeroed
  // whenever the write enable is low.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      rf_we_o    <= 1'b0;
      rf_waddr_o <= '0;
      rf_wdata_o <= '0;
      stall_o    <= 1'b0;
      hi_q       <= '0;
      hi_addr_q  <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments. Every flop
      // then samples the values from before the edge, whatever order these
      // statements are written in.
      case (state)
        IDLE: begin
          if (accept) begin
            rf_we_o    <= (sel_addr != 5'd0);
            rf_waddr_o <= (sel_addr != 5'd0) ? sel_addr : 5'd0;
            rf_wdata_o <= (sel_addr != 5'd0) ? sel_data : '0;
            if (start_pair) begin
              hi_q      <= hi_i;
              hi_addr_q <= dest_inc;
              stall_o   <= 1'b1;
              state     <= WB_HI;
            end else begin
              stall_o   <= 1'b0;
            end
          end else begin
            rf_we_o    <= 1'b0;
            rf_waddr_o <= '0;
            rf_wdata_o <= '0;
            stall_o    <= 1'b0;
          end
        end
        WB_HI: begin
          // The pair has already committed, so the ctrl_i and flush_i
          // values presented this cycle are ignored.
          rf_we_o    <= (hi_addr_q != 5'd0);
          rf_waddr_o <= (hi_addr_q != 5'd0) ? hi_addr_q : 5'd0;
          rf_wdata_o <= (hi_addr_q != 5'd0) ? hi_q : '0;
          stall_o    <= 1'b0;
          state      <= IDLE;
        end
        default: begin
          rf_we_o    <= 1'b0;
          rf_waddr_o <= '0;
          rf_wdata_o <= '0;
          stall_o    <= 1'b0;
          state      <= IDLE;
        end
      endcase
    end
  end

`ifdef STAGE4_RETIRE_CNT_EN
  // An instruction completes either on a single-write accept or on the
  // WB_HI edge of a pair. Suppressed writes to r0 still count.
  logic        retire;
  logic [15:0] retired_q;

  assign retire = (accept && !start_pair) || (state == WB_HI);

  // Saturating retirement counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      retired_q <= '0;
    end else if (retire && (retired_q != 16'hFFFF)) begin
      retired_q <= retired_q + 16'd1;
    end
  end

  assign retired_o = retired_q;
`else
  assign retired_o = '0;
`endif

endmodule

// File: tb/tb_stage4_wb_ctrl.sv
// tb_stage4_wb_ctrl -- directed, scoreboard-based bench for stage4_wb_ctrl.
// Expected writes are pushed when stimulus is driven. They are popped and
// compared one cycle later, 1 ns after the rising edge. The expected
// retirement count is reduced to 0 unless STAGE4_RETIRE_CNT_EN is defined.

module tb_stage4_wb_ctrl;

  localparam int DW = 32;

`ifdef STAGE4_RETIRE_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic [17:0]   ctrl;
  logic          flush;
  logic [DW-1:0] alu, mem, lo, hi, pc4;
  logic          rf_we;
  logic [4:0]    rf_waddr;
  logic [DW-1:0] rf_wdata;
  logic          stall;
  logic [15:0]   retired;

  stage4_wb_ctrl #(.DW(DW), .CW(18)) dut (
    .clk        (clk),
    .rst        (rst),
    .ctrl_i     (ctrl),
    .flush_i    (flush),
    .alu_i      (alu),
    .mem_i      (mem),
    .lo_i       (lo),
    .hi_i       (hi),
    .pc4_i      (pc4),
    .rf_we_o    (rf_we),
    .rf_waddr_o (rf_waddr),
    .rf_wdata_o (rf_wdata),
    .stall_o    (stall),
    .retired_o  (retired)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          we;
    logic [4:0]    addr;
    logic [DW-1:0] data;
    logic          stall;
    logic [15:0]   ret;
  } exp_t;

  exp_t        sb[$];
  int          n_pass  = 0;
  int          n_total = 0;
  int unsigned ret_model = 0;

  // Control word with the opcode and reserved fields deliberately non-zero
  function automatic logic [17:0] mk(input logic [4:0] dest, input logic rw,
                                     input logic m2r, input logic pair,
                                     input logic link, input logic valid);
    return {6'h2A, dest, rw, m2r, pair, link, 2'b11, valid};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic retire();
    if (ret_model != 32'hFFFF) ret_model++;
  endtask

  task automatic expect_out(input logic we, input logic [4:0] addr,
                            input logic [DW-1:0] data, input logic st);
    exp_t e;
    e.we    = we;
    e.addr  = addr;
    e.data  = data;
    e.stall = st;
    e.ret   = CNT_EN ? ret_model[15:0] : 16'h0;
    sb.push_back(e);
  endtask

  task automatic drive(input logic [17:0] c, input logic f,
                       input logic [DW-1:0] a, input logic [DW-1:0] m,
                       input logic [DW-1:0] l, input logic [DW-1:0] h,
                       input logic [DW-1:0] p);
    ctrl  = c;
    flush = f;
    alu   = a;
    mem   = m;
    lo    = l;
    hi    = h;
    pc4   = p;
  endtask

  task automatic tick(input string tag);
    exp_t e;
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      check({tag, ".sb_empty"}, 64'd1, 64'd0);
    end else begin
      e = sb.pop_front();
      check({tag, ".we"},    64'(rf_we),    64'(e.we));
      check({tag, ".waddr"}, 64'(rf_waddr), 64'(e.addr));
      check({tag, ".wdata"}, 64'(rf_wdata), 64'(e.data));
      check({tag, ".stall"}, 64'(stall),    64'(e.stall));
      check({tag, ".ret"},   64'(retired),  64'(e.ret));
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, ".we"},    64'(rf_we),    64'd0);
    check({tag, ".waddr"}, 64'(rf_waddr), 64'd0);
    check({tag, ".wdata"}, 64'(rf_wdata), 64'd0);
    check({tag, ".stall"}, 64'(stall),    64'd0);
    check({tag, ".ret"},   64'(retired),  64'd0);
  endtask

  initial begin
    rst = 1'b1;
    drive('0, 1'b0, '0, '0, '0, '0, '0);
    #2;
    check_zero("reset");

    // Release reset, then accept a single ALU write on the first edge
    @(negedge clk);
    rst = 1'b0;
    drive(mk(5'd5, 1, 0, 0, 0, 1), 0, 32'h1234_5678, 32'h0BAD_0001,
          32'h0BAD_0002, 32'h0BAD_0003, 32'h0BAD_0004);
    retire();
    expect_out(1, 5'd5, 32'h1234_5678, 0);
    tick("alu");

    // Pair write to 8/9. The new ctrl_i presented in cycle 1 is ignored,
    // and hi_i changes so the write must use the latched value.
    drive(mk(5'd8, 1, 0, 1, 0, 1), 0, 32'h0BAD_0011, 32'h0BAD_0012,
          32'hAAAA_0001, 32'hBBBB_0002, 32'h0BAD_0013);
    expect_out(1, 5'd8, 32'hAAAA_0001, 1);
    tick("pair_lo");
    drive(mk(5'd3, 1, 0, 0, 0, 1), 0, 32'hDEAD_0003, '0, '0,
          32'hCCCC_0000, '0);
    retire();
    expect_out(1, 5'd9, 32'hBBBB_0002, 0);
    tick("pair_hi");
    drive(mk(5'd3, 1, 0, 0, 0, 0), 0, 32'hDEAD_0003, '0, '0, '0, '0);
    expect_out(0, 5'd0, '0, 0);
    tick("pair_after");

    // Link beats mem_to_reg and pair_write, so no WB_HI follows
    drive(mk(5'd4, 1, 1, 1, 1, 1), 0, 32'h0BAD_0021, 32'h0BAD_0022,
          32'h0BAD_0023, 32'h0BAD_0024, 32'h0000_0104);
    retire();
    expect_out(1, 5'd31, 32'h0000_0104, 0);
    tick("link");
    drive(mk(5'd7, 1, 0, 0, 0, 1), 1, 32'h0000_0777, '0, '0, '0, '0);
    expect_out(0, 5'd0, '0, 0);
    tick("flush");

    // Pair to 31: the hi half wraps to r0 and is suppressed, but retires
    drive(mk(5'd31, 1, 0, 1, 0, 1), 0, '0, '0, 32'h1111_0000,
          32'h2222_0000, '0);
    expect_out(1, 5'd31, 32'h1111_0000, 1);
    tick("wrap_lo");
    drive(mk(5'd9, 1, 0, 0, 0, 1), 0, 32'h0000_0999, '0, '0, '0, '0);
    retire();
    expect_out(0, 5'd0, '0, 0);
    tick("wrap_hi");
    drive(mk(5'd2, 1, 0, 0, 0, 1), 0, 32'h0000_0222, '0, '0, '0, '0);
    retire();
    expect_out(1, 5'd2, 32'h0000_0222, 0);
    tick("wrap_idle");

    // Memory load data
    drive(mk(5'd12, 1, 1, 0, 0, 1), 0, 32'h0BAD_0031, 32'h4D45_4D00,
          '0, '0, '0);
    retire();
    expect_out(1, 5'd12, 32'h4D45_4D00, 0);
    tick("mem");

    // Bubbles: valid=0, then reg_write=0
    drive(mk(5'd13, 1, 0, 0, 0, 0), 0, 32'h0000_0013, '0, '0, '0, '0);
    expect_out(0, 5'd0, '0, 0);
    tick("novalid");
    drive(mk(5'd13, 0, 0, 0, 0, 1), 0, 32'h0000_0013, '0, '0, '0, '0);
    expect_out(0, 5'd0, '0, 0);
    tick("norw");

    // Write to r0 is suppressed but still retires
    drive(mk(5'd0, 1, 0, 0, 0, 1), 0, 32'h0000_00FF, '0, '0, '0, '0);
    retire();
    expect_out(0, 5'd0, '0, 0);
    tick("r0");

    // Pair to r0: lo suppressed with stall still high, hi goes to r1
    drive(mk(5'd0, 1, 0, 1, 0, 1), 0, '0, '0, 32'h0000_00A0,
          32'h0000_00A1, '0);
    expect_out(0, 5'd0, '0, 1);
    tick("pair0_lo");
    drive('0, 0, '0, '0, '0, '0, '0);
    retire();
    expect_out(1, 5'd1, 32'h0000_00A1, 0);
    tick("pair0_hi");

    // Reset in the middle of WB_HI drops the hi-half write
    drive(mk(5'd20, 1, 0, 1, 0, 1), 0, '0, '0, 32'h5555_0014,
          32'h6666_0015, '0);
    expect_out(1, 5'd20, 32'h5555_0014, 1);
    tick("rstmid_lo");
    #3;
    rst = 1'b1;
    ret_model = 0;
    #1;
    check_zero("rstmid_async");
    #2;
    rst = 1'b0;
    drive(mk(5'd6, 1, 0, 0, 0, 1), 0, 32'h0000_0666, '0, '0, '0, '0);
    retire();
    expect_out(1, 5'd6, 32'h0000_0666, 0);
    tick("rstmid_first");
    drive('0, 0, '0, '0, '0, '0, '0);
    expect_out(0, 5'd0, '0, 0);
    tick("rstmid_after");

`ifdef STAGE4_RETIRE_CNT_EN
    // Saturation: 65537 retirements from reset
    @(negedge clk);
    rst = 1'b1;
    #1;
    rst = 1'b0;
    drive(mk(5'd10, 1, 0, 0, 0, 1), 0, 32'h0000_0A0A, '0, '0, '0, '0);
    repeat (65534) @(posedge clk);
    #1;
    check("sat_fffe", 64'(retired), 64'hFFFE);
    repeat (3) @(posedge clk);
    #1;
    check("sat_ffff", 64'(retired), 64'hFFFF);
    check("sat_we", 64'(rf_we), 64'd1);
`endif

    check("sb_drained", 64'(sb.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
